hit_point_fx: RTL and testbench
===============================

Name: hit_point_fx

Overview:
- Parametrised fixed-point successor to the float hit-point/normal stage of the ray-tracer shading path.
- Takes one bundle per beat: ray origin/direction, hit distance t, object centre/axis and object kind. Emits the hit point, the unnormalised surface normal, a cylinder-height invalid flag and a band flag.
- Supports sphere, capped-height cylinder and plane modes.
- Uses a single-bundle AXI-stream input and output with whole-pipeline stall, so no per-operand alignment pipes are needed.

Parameters:
- WIDTH, 32: signed fixed-point word width, two's complement.
- FRAC, 16: fractional bits.
- TAG_W, 8: opaque sideband carried from input to output, e.g. pixel index.
- PIN_HEIGHT, 32'h0078_0000: cylinder height limit (120.0 in Q16.16).
- BAND_LO, 0: lower bound of the band flag, in axial units.
- BAND_HI, 0: upper bound of the band flag. Equal bounds disable the flag.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- s_axis_ray_tdata  in  6*WIDTH  origin [2:0], direction [5:3].
- s_axis_t_tdata  in  WIDTH  hit distance t.
- s_axis_obj_tdata  in  6*WIDTH  centre [2:0], unit axis or plane normal [5:3].
- s_axis_mode  in  2  0 = sphere, 1 = cylinder, 2 = plane, 3 = reserved (treated as sphere).
- s_axis_tag  in  TAG_W  sideband.
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- m_axis_hit_tdata  out  3*WIDTH  hit point.
- m_axis_normal_tdata  out  3*WIDTH  normal.
- m_axis_invalid  out  1  cylinder hit outside [0, PIN_HEIGHT].
- m_axis_band  out  1  BAND_LO < h < BAND_HI.
- m_axis_tag  out  TAG_W
- m_axis_tvalid  out  1
- m_axis_tready  in  1

Behaviour:
- Reset: the clock and reset are fixed as one clock, aclk, with areset asynchronous and active-high. While reset is asserted, every stage valid bit clears, m_axis_tvalid = 0 and all data outputs = 0. A reset mid-flight discards all in-flight beats. s_axis_tready = 1 on the first cycle after reset deasserts.
- Pipeline: 6 stages, latency exactly 6 cycles from accepted input to m_axis_tvalid when unstalled; throughput is 1 beat per cycle.
- advance = !v6 || m_axis_tready. All stage registers load only when advance is high.
- s_axis_tready = advance. Bubbles are not collapsed.
- Output data and flags are stable while m_axis_tvalid is high and m_axis_tready is low.
- S1: q_i = t*d_i.
- S2: hp_i = o_i + q_i; then p_i = hp_i - c_i.
- S3: r_i = p_i*a_i.
- S4: h = r_0 + r_1 + r_2.
- S5: s_i = h*a_i; compute the flags.
- S6: output register. The normal is selected by mode:
  - sphere: n_i = p_i.
  - cylinder: n_i = p_i - s_i.
  - plane: n_i = a_i.
- Multiply: full 2*WIDTH signed product, arithmetic shift right by FRAC (truncation toward −inf), then saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Add/sub, including the 3-term sum: computed at WIDTH+2 bits, then saturated to WIDTH.
- Flags:
  - invalid = (mode==1) && (h < 0 || h > PIN_HEIGHT). Both boundaries are inclusive-valid: h = 0 and h = PIN_HEIGHT are valid.
  - band = (mode==1) && (BAND_LO < h) && (h < BAND_HI). Strict on both sides.
  - Sphere and plane modes force both flags to 0.
- Tag and mode travel with the beat unchanged.
- Simultaneous events:
  - Input accept and output consume in the same cycle: both occur, and the pipeline shifts.
  - m_axis_tready low with a full pipeline: s_axis_tready drops combinationally in the same cycle.

Decomposition:
- Package hit_fx_pkg:
  - hit_mode_e enum {HIT_SPHERE, HIT_CYL, HIT_PLANE}.
  - Function sat_add(a, b, sub).
  - Q-format constants ONE = 1 << FRAC.
  - Vector typedef vec3_t as [2:0][WIDTH-1:0].
- Sub-module fx_mul_sat: combinational signed multiply with shift and saturate, parametrised by WIDTH and FRAC. Instantiate 9 times: 3 at S1, 3 at S3, 3 at S5.
- Stage registers are inline in the top-level module.

Test Plan:
- Sphere: o = 0, d = (1.0, 0, 0), t = 2.0, c = (3.0, 0, 0), mode = 0, tag = 0x11.
  -> after 6 cycles, hit = (2.0, 0, 0), normal = (−1.0, 0, 0), invalid = 0, band = 0, tag = 0x11.
- Cylinder valid: o = 0, d = (0, 1.0, 0), t = 1.0, c = (1.0, 0, 0), a = (0, 1.0, 0), mode = 1.
  -> h = 1.0, normal = (−1.0, 0, 0), invalid = 0.
- Cylinder invalid: same setup with t = −1.0 -> invalid = 1.
- Cylinder upper boundary: t = 120.0 -> invalid = 0; t = 120.0 + 1 LSB -> invalid = 1.
- Backpressure: 10 back-to-back beats with incrementing tag, m_axis_tready held low for cycles 3–8.
  -> s_axis_tready low while the pipeline is full; 10 outputs arrive in order with none lost or duplicated; data is held stable while stalled.
- Saturation and reset: t = 0x7FFF_FFFF with d_x = 2.0 -> hit_x = 0x7FFF_FFFF.
  -> separately, assert areset with 3 beats in flight: m_axis_tvalid drops immediately and no stale beat appears after release.

Source files
------------

// File: rtl/hit_fx_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : hit_fx_pkg
//  Purpose : Shared types, Q-format constants and saturating add helpers for
//            the fixed-point hit-point / normal pipeline.
//  Contents: hit_mode_e object kinds, vec3_t default-width vector, ONE,
//            sat_clip / sat_add (saturating arithmetic on a 64-bit carrier,
//            valid for word widths up to 62 bits).
//  Revision: 1.0  initial release
// ============================================================================
package hit_fx_pkg;

  localparam int FX_WIDTH = 32;
  localparam int FX_FRAC  = 16;

  // 1.0 in the default Q format
  localparam logic [FX_WIDTH-1:0] ONE = 32'd1 << FX_FRAC;

  typedef logic [2:0][FX_WIDTH-1:0] vec3_t;

  // Mode value 3 is reserved and behaves like HIT_SPHERE.
  typedef enum logic [1:0] {
    HIT_SPHERE = 2'd0,
    HIT_CYL    = 2'd1,
    HIT_PLANE  = 2'd2
  } hit_mode_e;

  // Clamp a wide signed value into the range of a w-bit two's complement word.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x,
                                                  input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

  // a + b (sub = 0) or a - b (sub = 1), saturated to w bits. Operands are
  // sign-extended w-bit words, so the 64-bit sum never wraps.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input logic               sub,
                                                 input int unsigned        w);
    return sat_clip(sub ? (a - b) : (a + b), w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fx_mul_sat.sv
`default_nettype none
// ============================================================================
//  Module  : fx_mul_sat
//  Purpose : Combinational signed fixed-point multiply. Full 2*WIDTH product,
//            arithmetic shift right by FRAC (floor), saturate to WIDTH.
//  Ports   : i_a, i_b  signed WIDTH-bit operands
//            o_p       signed WIDTH-bit saturated product
//  Revision: 1.0  initial release
// ============================================================================
module fx_mul_sat #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_p
);

  localparam logic signed [2*WIDTH-1:0] c_max = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] c_min = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [2*WIDTH-1:0] w_shr;

  assign w_prod = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
  assign w_shr  = w_prod >>> FRAC;

  always_comb begin
    if (w_shr > c_max)      o_p = c_max[WIDTH-1:0];
    else if (w_shr < c_min) o_p = c_min[WIDTH-1:0];
    else                    o_p = w_shr[WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/hit_point_fx.sv
`default_nettype none
// ============================================================================
//  Module  : hit_point_fx
//  Purpose : 6-stage fixed-point hit point / unnormalised normal pipeline for
//            sphere, capped cylinder and plane objects, with whole-pipeline
//            stall on an AXI-stream style handshake.
//  Ports   : aclk, areset (async, active-high)
//            s_axis_ray_tdata  origin [2:0], direction [5:3]
//            s_axis_t_tdata    hit distance t
//            s_axis_obj_tdata  centre [2:0], unit axis / plane normal [5:3]
//            s_axis_mode, s_axis_tag, s_axis_tvalid, s_axis_tready
//            m_axis_hit_tdata, m_axis_normal_tdata, m_axis_invalid,
//            m_axis_band, m_axis_tag, m_axis_tvalid, m_axis_tready
//  Revision: 1.0  initial release
// ============================================================================
module hit_point_fx
  import hit_fx_pkg::*;
#(
  parameter int                      WIDTH      = 32,
  parameter int                      FRAC       = 16,
  parameter int                      TAG_W      = 8,
  parameter logic signed [WIDTH-1:0] PIN_HEIGHT = 32'h0078_0000,
  parameter logic signed [WIDTH-1:0] BAND_LO    = '0,
  parameter logic signed [WIDTH-1:0] BAND_HI    = '0
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [6*WIDTH-1:0]   s_axis_ray_tdata,
  input  logic [WIDTH-1:0]     s_axis_t_tdata,
  input  logic [6*WIDTH-1:0]   s_axis_obj_tdata,
  input  logic [1:0]           s_axis_mode,
  input  logic [TAG_W-1:0]     s_axis_tag,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [3*WIDTH-1:0]   m_axis_hit_tdata,
  output logic [3*WIDTH-1:0]   m_axis_normal_tdata,
  output logic                 m_axis_invalid,
  output logic                 m_axis_band,
  output logic [TAG_W-1:0]     m_axis_tag,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready
);

  typedef logic [2:0][WIDTH-1:0] vecw_t;

  function automatic logic [WIDTH-1:0] add_w(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             sub);
    logic signed [63:0] res;
    res = sat_add(64'($signed(a)), 64'($signed(b)), sub, WIDTH);
    return res[WIDTH-1:0];
  endfunction

  // Input bundle unpacking
  vecw_t w_o, w_d, w_c, w_a;
  assign w_o = s_axis_ray_tdata[3*WIDTH-1:0];
  assign w_d = s_axis_ray_tdata[6*WIDTH-1:3*WIDTH];
  assign w_c = s_axis_obj_tdata[3*WIDTH-1:0];
  assign w_a = s_axis_obj_tdata[6*WIDTH-1:3*WIDTH];

  // Stage registers
  logic r1_v, r2_v, r3_v, r4_v, r5_v, r6_v;
  logic [1:0]       r1_mode, r2_mode, r3_mode, r4_mode, r5_mode;
  logic [TAG_W-1:0] r1_tag, r2_tag, r3_tag, r4_tag, r5_tag, r6_tag;
  vecw_t r1_q, r1_o, r1_c, r1_a;
  vecw_t r2_hp, r2_p, r2_a;
  vecw_t r3_r, r3_hp, r3_p, r3_a;
  logic [WIDTH-1:0] r4_h;
  vecw_t r4_hp, r4_p, r4_a;
  vecw_t r5_s, r5_hp, r5_p, r5_a;
  logic  r5_inv, r5_band;
  vecw_t r6_hit, r6_nrm;
  logic  r6_inv, r6_band;

  // Whole-pipeline stall: everything moves only when the output slot frees up
  logic w_adv;
  assign w_adv         = !r6_v || m_axis_tready;
  assign s_axis_tready = w_adv;

  // Multipliers: S1 t*d, S3 p*a, S5 h*a
  vecw_t w_q, w_r, w_s;
  for (genvar i = 0; i < 3; i++) begin : g_mul
    fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_s1 (
      .i_a(s_axis_t_tdata), .i_b(w_d[i]),  .o_p(w_q[i]));
    fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_s3 (
      .i_a(r2_p[i]),        .i_b(r2_a[i]), .o_p(w_r[i]));
    fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_s5 (
      .i_a(r4_h),           .i_b(r4_a[i]), .o_p(w_s[i]));
  end

  // S2: hit point and centre-relative vector
  vecw_t w_hp, w_p;
  always_comb begin
    w_hp = '0;
    w_p  = '0;
    for (int i = 0; i < 3; i++) begin
      w_hp[i] = add_w(r1_o[i], r1_q[i], 1'b0);
      w_p[i]  = add_w(w_hp[i], r1_c[i], 1'b1);
    end
  end

  // S4: axial projection, one saturation over the full 3-term sum
  logic [WIDTH-1:0]   w_h;
  logic signed [63:0] w_hsum;
  always_comb begin
    w_hsum = sat_clip(64'($signed(r3_r[0])) + 64'($signed(r3_r[1])) +
                      64'($signed(r3_r[2])), WIDTH);
    w_h    = w_hsum[WIDTH-1:0];
  end

  // S5 flags, only meaningful for cylinders
  logic signed [WIDTH-1:0] w_h_s;
  logic w_cyl, w_inv, w_band;
  assign w_h_s  = r4_h;
  assign w_cyl  = (r4_mode == HIT_CYL);
  assign w_inv  = w_cyl && (w_h_s[WIDTH-1] || (w_h_s > PIN_HEIGHT));
  assign w_band = w_cyl && (w_h_s > BAND_LO) && (w_h_s < BAND_HI);

  // S6: normal selection (reserved mode falls through to sphere)
  vecw_t w_nrm;
  always_comb begin
    w_nrm = r5_p;
    case (r5_mode)
      HIT_CYL: begin
        for (int i = 0; i < 3; i++) w_nrm[i] = add_w(r5_p[i], r5_s[i], 1'b1);
      end
      HIT_PLANE: w_nrm = r5_a;
      default:   w_nrm = r5_p;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r1_v <= 1'b0; r2_v <= 1'b0; r3_v <= 1'b0;
      r4_v <= 1'b0; r5_v <= 1'b0; r6_v <= 1'b0;
      r1_mode <= '0; r2_mode <= '0; r3_mode <= '0; r4_mode <= '0; r5_mode <= '0;
      r1_tag <= '0; r2_tag <= '0; r3_tag <= '0; r4_tag <= '0; r5_tag <= '0; r6_tag <= '0;
      r1_q <= '0; r1_o <= '0; r1_c <= '0; r1_a <= '0;
      r2_hp <= '0; r2_p <= '0; r2_a <= '0;
      r3_r <= '0; r3_hp <= '0; r3_p <= '0; r3_a <= '0;
      r4_h <= '0; r4_hp <= '0; r4_p <= '0; r4_a <= '0;
      r5_s <= '0; r5_hp <= '0; r5_p <= '0; r5_a <= '0; r5_inv <= 1'b0; r5_band <= 1'b0;
      r6_hit <= '0; r6_nrm <= '0; r6_inv <= 1'b0; r6_band <= 1'b0;
    end else if (w_adv) begin
      r1_v <= s_axis_tvalid; r1_mode <= s_axis_mode; r1_tag <= s_axis_tag;
      r1_q <= w_q; r1_o <= w_o; r1_c <= w_c; r1_a <= w_a;

      r2_v <= r1_v; r2_mode <= r1_mode; r2_tag <= r1_tag;
      r2_hp <= w_hp; r2_p <= w_p; r2_a <= r1_a;

      r3_v <= r2_v; r3_mode <= r2_mode; r3_tag <= r2_tag;
      r3_r <= w_r; r3_hp <= r2_hp; r3_p <= r2_p; r3_a <= r2_a;

      r4_v <= r3_v; r4_mode <= r3_mode; r4_tag <= r3_tag;
      r4_h <= w_h; r4_hp <= r3_hp; r4_p <= r3_p; r4_a <= r3_a;

      r5_v <= r4_v; r5_mode <= r4_mode; r5_tag <= r4_tag;
      r5_s <= w_s; r5_hp <= r4_hp; r5_p <= r4_p; r5_a <= r4_a;
      r5_inv <= w_inv; r5_band <= w_band;

      r6_v <= r5_v; r6_tag <= r5_tag;
      r6_hit <= r5_hp; r6_nrm <= w_nrm; r6_inv <= r5_inv; r6_band <= r5_band;
    end
  end

  assign m_axis_hit_tdata    = r6_hit;
  assign m_axis_normal_tdata = r6_nrm;
  assign m_axis_invalid      = r6_inv;
  assign m_axis_band         = r6_band;
  assign m_axis_tag          = r6_tag;
  assign m_axis_tvalid       = r6_v;

endmodule
`default_nettype wire

// File: tb/tb_hit_point_fx.sv
`default_nettype none
// ============================================================================
//  Module  : tb_hit_point_fx
//  Purpose : Self-checking bench for hit_point_fx: directed cases, backpressure,
//            saturation, mid-flight reset and randomized beats scored against
//            an arithmetic reference model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_hit_point_fx;

  localparam longint PIN  = 64'sh0078_0000;
  localparam longint BLO  = 0;
  localparam longint BHI  = 64'sh0005_0000;

  typedef struct {
    int         o[3];
    int         d[3];
    int         c[3];
    int         a[3];
    int         t;
    logic [1:0] mode;
    logic [7:0] tag;
  } beat_t;

  typedef struct {
    logic [95:0] hit;
    logic [95:0] nrm;
    logic        inv;
    logic        band;
    logic [7:0]  tag;
  } exp_t;

  logic         aclk = 1'b0;
  logic         areset;
  logic [191:0] ray, obj;
  logic [31:0]  t_in;
  logic [1:0]   mode;
  logic [7:0]   tag;
  logic         s_tvalid, s_tready;
  logic [95:0]  hit, nrm;
  logic         inv, band;
  logic [7:0]   mtag;
  logic         mvalid, mready;

  int    total = 0;
  int    bad   = 0;
  int    outs  = 0;
  exp_t  sb[$];
  beat_t cur;

  always #5 aclk = ~aclk;

  hit_point_fx #(
    .WIDTH(32), .FRAC(16), .TAG_W(8),
    .PIN_HEIGHT(32'h0078_0000), .BAND_LO(32'h0), .BAND_HI(32'h0005_0000)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_ray_tdata(ray), .s_axis_t_tdata(t_in), .s_axis_obj_tdata(obj),
    .s_axis_mode(mode), .s_axis_tag(tag), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_hit_tdata(hit), .m_axis_normal_tdata(nrm),
    .m_axis_invalid(inv), .m_axis_band(band), .m_axis_tag(mtag),
    .m_axis_tvalid(mvalid), .m_axis_tready(mready)
  );

  // ---------------- reference model ----------------
  function automatic longint clip(input longint x);
    if (x > 64'sd2147483647)  return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return clip((a * b) >>> 16);
  endfunction

  function automatic exp_t model(input beat_t b);
    exp_t   e;
    longint hp[3], p[3], r[3], s[3], n[3], h;
    logic   cyl;
    cyl = (b.mode == 2'd1);
    for (int i = 0; i < 3; i++) begin
      hp[i] = clip(longint'(b.o[i]) + fmul(longint'(b.t), longint'(b.d[i])));
      p[i]  = clip(hp[i] - longint'(b.c[i]));
      r[i]  = fmul(p[i], longint'(b.a[i]));
    end
    h = clip(r[0] + r[1] + r[2]);
    for (int i = 0; i < 3; i++) begin
      s[i] = fmul(h, longint'(b.a[i]));
      if (cyl)                 n[i] = clip(p[i] - s[i]);
      else if (b.mode == 2'd2) n[i] = longint'(b.a[i]);
      else                     n[i] = p[i];
      e.hit[i*32 +: 32] = hp[i][31:0];
      e.nrm[i*32 +: 32] = n[i][31:0];
    end
    e.inv  = cyl && (h < 0 || h > PIN);
    e.band = cyl && (h > BLO) && (h < BHI);
    e.tag  = b.tag;
    return e;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [255:0] obs, input logic [255:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp_v);
    end
  endtask

  function automatic logic [95:0] v3(input int x, input int y, input int z);
    return {z, y, x};
  endfunction

  function automatic beat_t zero_beat();
    beat_t b;
    for (int i = 0; i < 3; i++) begin
      b.o[i] = 0; b.d[i] = 0; b.c[i] = 0; b.a[i] = 0;
    end
    b.t = 0; b.mode = 2'd0; b.tag = 8'd0;
    return b;
  endfunction

  task automatic drive(input beat_t b);
    cur = b;
    for (int i = 0; i < 3; i++) begin
      ray[i*32 +: 32]     = b.o[i];
      ray[(3+i)*32 +: 32] = b.d[i];
      obj[i*32 +: 32]     = b.c[i];
      obj[(3+i)*32 +: 32] = b.a[i];
    end
    t_in = b.t; mode = b.mode; tag = b.tag; s_tvalid = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input beat_t b);
    int g;
    drive(b);
    g = 0;
    @(negedge aclk);
    while (!s_tready && g < 200) begin @(negedge aclk); g++; end
    if (g >= 200) chk("send_timeout", s_tready, 1'b1);
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
  endtask

  // Single beat into an idle pipeline: measures latency and checks constants.
  task automatic one_shot(input string nm, input beat_t b, input logic [95:0] eh,
                          input logic [95:0] en, input logic ei);
    int n;
    drive(b);
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge aclk); n++;
      if (mvalid) break;
    end
    chk({nm, "_latency"}, n, 6);
    chk({nm, "_hit"}, hit, eh);
    chk({nm, "_normal"}, nrm, en);
    chk({nm, "_invalid"}, inv, ei);
    chk({nm, "_tag"}, mtag, b.tag);
    @(posedge aclk); #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 300) begin @(posedge aclk); g++; end
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  // ---------------- scoreboard processes ----------------
  always @(negedge aclk) begin
    if (!areset && s_tvalid && s_tready) sb.push_back(model(cur));
  end

  logic         stalled = 1'b0;
  logic [202:0] held;
  exp_t         e;
  always @(negedge aclk) begin
    if (areset) begin
      chk("reset_tvalid", mvalid, 1'b0);
      chk("reset_data", {hit, nrm, inv, band, mtag}, '0);
      sb.delete();
      stalled = 1'b0;
    end else begin
      chk("tready_rule", s_tready, !mvalid || mready);
      if (stalled) chk("stall_hold", {hit, nrm, inv, band, mtag, mvalid}, held);
      if (mvalid && mready) begin
        outs++;
        if (sb.size() == 0) chk("unexpected_beat", mvalid, 1'b0);
        else begin
          e = sb.pop_front();
          chk("sb_hit", hit, e.hit);
          chk("sb_normal", nrm, e.nrm);
          chk("sb_flags", {inv, band}, {e.inv, e.band});
          chk("sb_tag", mtag, e.tag);
        end
      end
      stalled = mvalid && !mready;
      held    = {hit, nrm, inv, band, mtag, mvalid};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  logic  rnd_done = 1'b0;
  initial begin
    beat_t b;
    int    outs0;
    areset = 1'b1; s_tvalid = 1'b0; mready = 1'b1;
    ray = '0; obj = '0; t_in = '0; mode = '0; tag = '0;
    cur = zero_beat();
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("tready_after_reset", s_tready, 1'b1);
    chk("tvalid_after_reset", mvalid, 1'b0);
    @(posedge aclk); #1;

    // Sphere
    b = zero_beat();
    b.d[0] = 32'h0001_0000; b.t = 32'h0002_0000; b.c[0] = 32'h0003_0000; b.tag = 8'h11;
    one_shot("sphere", b, v3(32'h0002_0000, 0, 0), v3(32'hFFFF_0000, 0, 0), 1'b0);

    // Cylinder along y, centre at x = 1.0
    b = zero_beat();
    b.d[1] = 32'h0001_0000; b.c[0] = 32'h0001_0000; b.a[1] = 32'h0001_0000;
    b.mode = 2'd1; b.tag = 8'h21;
    b.t = 32'h0001_0000;
    one_shot("cyl_valid", b, v3(0, 32'h0001_0000, 0), v3(32'hFFFF_0000, 0, 0), 1'b0);
    b.t = 32'hFFFF_0000; b.tag = 8'h22;
    one_shot("cyl_below", b, v3(0, 32'hFFFF_0000, 0), v3(32'hFFFF_0000, 0, 0), 1'b1);
    b.t = 32'h0078_0000; b.tag = 8'h23;
    one_shot("cyl_top", b, v3(0, 32'h0078_0000, 0), v3(32'hFFFF_0000, 0, 0), 1'b0);
    b.t = 32'h0078_0001; b.tag = 8'h24;
    one_shot("cyl_over", b, v3(0, 32'h0078_0001, 0), v3(32'hFFFF_0000, 0, 0), 1'b1);
    b.t = 32'h0000_0000; b.tag = 8'h25;
    one_shot("cyl_zero", b, v3(0, 0, 0), v3(32'hFFFF_0000, 0, 0), 1'b0);

    // Saturation of t*d and the following add
    b = zero_beat();
    b.t = 32'h7FFF_FFFF; b.d[0] = 32'h0002_0000; b.tag = 8'h31;
    one_shot("sat", b, v3(32'h7FFF_FFFF, 0, 0), v3(32'h7FFF_FFFF, 0, 0), 1'b0);

    // Backpressure: 10 back-to-back beats, sink stalls in cycles 3..8
    outs0 = outs;
    fork
      begin
        repeat (3) @(posedge aclk);
        #1 mready = 1'b0;
        repeat (4) @(negedge aclk);
        chk("bp_tready_low", s_tready, 1'b0);
        repeat (3) @(posedge aclk);
        #1 mready = 1'b1;
      end
    join_none
    for (int k = 0; k < 10; k++) begin
      b = zero_beat();
      b.o[0] = k * 32'h0000_8000; b.d[2] = 32'h0001_0000; b.t = k * 32'h0001_0000;
      b.a[2] = 32'h0001_0000; b.mode = 2'(k % 3); b.tag = 8'h40 + 8'(k);
      send(b);
    end
    drain();
    chk("bp_count", outs - outs0, 10);

    // Reset with three beats in flight
    for (int k = 0; k < 3; k++) begin
      b = zero_beat();
      b.d[0] = 32'h0001_0000; b.t = 32'h0001_0000; b.tag = 8'h60 + 8'(k);
      send(b);
    end
    areset = 1'b1;
    outs0 = outs;
    @(negedge aclk);
    chk("midreset_tvalid", mvalid, 1'b0);
    @(posedge aclk); #1 areset = 1'b0;
    repeat (15) @(posedge aclk);
    #1;
    chk("midreset_no_stale", outs - outs0, 0);

    // Randomized beats with random sink readiness
    fork
      begin
        while (!rnd_done) begin
          @(posedge aclk); #1;
          mready = ($urandom_range(0, 3) != 0);
        end
        mready = 1'b1;
      end
    join_none
    outs0 = outs;
    for (int k = 0; k < 200; k++) begin
      b.mode = 2'($urandom_range(0, 3));
      b.tag  = 8'(k);
      for (int i = 0; i < 3; i++) begin
        b.o[i] = int'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000;
        b.c[i] = int'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000;
        b.d[i] = int'($urandom_range(0, 32'h0003_0000)) - 32'h0001_8000;
        b.a[i] = int'($urandom_range(0, 32'h0003_0000)) - 32'h0001_8000;
      end
      b.t = int'($urandom_range(0, 32'h00F0_0000)) - 32'h0010_0000;
      if ($urandom_range(0, 9) == 0) b.t = int'($urandom);
      if ($urandom_range(0, 9) == 0) b.o[1] = int'($urandom);
      send(b);
      if ($urandom_range(0, 4) == 0) begin @(posedge aclk); #1; end
    end
    rnd_done = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    drain();
    chk("rand_count", outs - outs0, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
